tick_prescaler: RTL and testbench
=================================

TICK_PRESCALER -- requirements
Module: tick_prescaler

Interface
REQ-001 SHALL have parameter N_BIT, default 16: prescaler count and divide-value width.
REQ-002 SHALL have parameter CNT_BIT, default 16: tick event counter width.
REQ-003 SHALL have parameter DIV_DEFAULT, default 3: divide value after reset; tick period is DIV_DEFAULT+1 cycles.
REQ-004 SHALL have one clock and a synchronous, active-high reset; no other clock or reset inputs.
REQ-005 SHALL have port clkin, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: run/pause control.
REQ-008 SHALL have port div_load, input, 1 bit: loads div_value into the divide register.
REQ-009 SHALL have port div_value, input, N_BIT: new divide value; period is div_value+1 cycles.
REQ-010 SHALL have port mode, input, 1 bit: 0 = periodic, 1 = one-shot.
REQ-011 SHALL have port sat, input, 1 bit: 0 = counter wraps, 1 = counter saturates.
REQ-012 SHALL have port clr, input, 1 bit: synchronous clear of counter.
REQ-013 SHALL have port tick, output, 1 bit: single-cycle tick pulse.
REQ-014 SHALL have port count, output, N_BIT: current prescaler value.
REQ-015 SHALL have port counter, output, CNT_BIT: number of ticks emitted.
REQ-016 SHALL have port wrap, output, 1 bit: single-cycle pulse when counter wraps to 0.
REQ-017 SHALL have port cnt_max, output, 1 bit: high while counter is all ones.
REQ-018 SHALL have port busy, output, 1 bit: high in RUN or HOLD.

Function
REQ-019 SHALL implement states IDLE, RUN, HOLD, DONE.
REQ-020 SHALL transition IDLE->RUN when enable=1, sampling mode into mode_reg on that edge.
REQ-021 SHALL transition RUN->HOLD when enable=0; HOLD->RUN when enable=1; HOLD freezes count and holds tick=0.
REQ-022 SHALL, in RUN: if count==div_reg, register tick=1 and count=0; otherwise register tick=0 and count=count+1.
REQ-023 SHALL transition RUN->DONE on the tick edge when mode_reg=1; DONE holds count=0 and tick=0, and goes to IDLE when enable=0.
REQ-024 SHALL force count=0 and tick=0 in IDLE.
REQ-025 SHALL, on div_load=1: div_reg<=div_value, count<=0, tick<=0; takes priority over tick generation; in DONE with enable=1, re-arms to RUN.
REQ-026 SHALL hold tick high continuously in periodic RUN when div_reg=0.
REQ-027 SHALL increment counter on the same clkin edge that sets tick=1; no logic clocked by tick.
REQ-028 SHALL, at counter all ones on a tick with sat=0, set counter to 0 and pulse wrap for one cycle; with sat=1, hold counter and keep wrap=0.
REQ-029 SHALL give clr priority over a simultaneous increment: counter<=0, wrap=0.
REQ-030 SHALL keep div_reg unchanged when div_value changes without div_load.

Reset
REQ-031 SHALL give rst priority over all inputs.
REQ-032 SHALL, on rst: state=IDLE, div_reg=DIV_DEFAULT, mode_reg=0, and tick, count, counter, wrap, cnt_max, busy all 0.
REQ-033 SHALL, on rst asserted mid-RUN, discard any pending tick; the first tick after release follows REQ-022 from count=0.

Structure
REQ-034 SHALL place the state encoding and the DIV_DEFAULT default constant in shared package tick_pkg.
REQ-035 SHALL implement counter, clr, sat, wrap and cnt_max in sub-module tick_event_counter (parameter CNT_BIT) instantiated once.

Verification
REQ-036 SHALL cover: reset, then enable=1 with default div -> tick on cycles 4, 8, 12; counter=1, 2, 3.
REQ-037 SHALL cover: div_load with div_value=0 in RUN -> tick high every cycle; counter increments each cycle.
REQ-038 SHALL cover: mode=1, div 3 -> exactly one tick, state DONE, busy=0; enable 0->1 -> a second single tick.
REQ-039 SHALL cover: CNT_BIT=4, sat=0, 16 ticks -> counter 15 then 0 with wrap pulse; sat=1 -> counter holds 15, cnt_max=1.
REQ-040 SHALL cover: enable=0 at count=2 for 5 cycles -> count holds 2, no tick; resume -> tick 2 cycles later.
REQ-041 SHALL cover: clr coincident with tick -> counter=0, wrap=0; rst at count=3 -> no tick, all outputs 0.

Source files
------------

// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared state encoding and reset divide value for the tick prescaler
package tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } tick_state_e;

    // Divide value after reset; tick period is this plus one cycles.
    localparam int TICK_DIV_DEFAULT = 3;

endpackage

// File: rtl/tick_event_counter.sv
// rtl/tick_event_counter.sv - counts emitted ticks with wrap/saturate and clear
module tick_event_counter #(
    parameter int CNT_BIT = 16
) (
    input  logic               clkin,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    input  logic               sat,
    output logic [CNT_BIT-1:0] counter,
    output logic               wrap,
    output logic               cnt_max
);

    logic [CNT_BIT-1:0] counter_q, counter_d;
    logic               wrap_q, wrap_d;

    // Clear wins over a coincident tick; all-ones either wraps or sticks.
    always_comb begin
        counter_d = counter_q;
        wrap_d    = 1'b0;
        if (clr) begin
            counter_d = '0;
        end else if (inc) begin
            if (&counter_q) begin
                if (!sat) begin
                    counter_d = '0;
                    wrap_d    = 1'b1;
                end
            end else begin
                counter_d = counter_q + CNT_BIT'(1);
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            counter_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            counter_q <= counter_d;
            wrap_q    <= wrap_d;
        end
    end

    assign counter = counter_q;
    assign wrap    = wrap_q;
    assign cnt_max = &counter_q;

endmodule

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - programmable tick prescaler with pause, one-shot and event counter
module tick_prescaler
    import tick_pkg::*;
#(
    parameter int N_BIT       = 16,
    parameter int CNT_BIT     = 16,
    parameter int DIV_DEFAULT = TICK_DIV_DEFAULT
) (
    input  logic               clkin,
    input  logic               rst,
    input  logic               enable,
    input  logic               div_load,
    input  logic [N_BIT-1:0]   div_value,
    input  logic               mode,
    input  logic               sat,
    input  logic               clr,
    output logic               tick,
    output logic [N_BIT-1:0]   count,
    output logic [CNT_BIT-1:0] counter,
    output logic               wrap,
    output logic               cnt_max,
    output logic               busy
);

    tick_state_e      state_q, state_d;
    logic [N_BIT-1:0] div_q, div_d;
    logic [N_BIT-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             run_step;

    // The prescaler advances on every enabled edge outside DONE, including
    // the edge that leaves IDLE or HOLD, so resume latency equals the
    // remaining distance to div_q.
    assign run_step = enable && (state_q != ST_DONE);

    always_comb begin
        div_d   = div_q;
        count_d = count_q;
        tick_d  = 1'b0;
        if (div_load) begin
            div_d   = div_value;
            count_d = '0;
        end else if (run_step) begin
            if (count_q == div_q) begin
                tick_d  = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + N_BIT'(1);
            end
        end else if (state_q == ST_IDLE || state_q == ST_DONE) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= N_BIT'(DIV_DEFAULT);
            mode_q  <= 1'b0;
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                end
            end
            ST_RUN:  if (!enable) state_d = ST_HOLD;
            ST_HOLD: if (enable) state_d = ST_RUN;
            ST_DONE: begin
                if (div_load && enable) begin
                    state_d = ST_RUN;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (tick_d && mode_d) begin
            state_d = ST_DONE;
        end
    end

    always_comb begin
        busy = (state_q == ST_RUN) || (state_q == ST_HOLD);
    end

    assign tick  = tick_q;
    assign count = count_q;

    tick_event_counter #(
        .CNT_BIT (CNT_BIT)
    ) u_event_counter (
        .clkin   (clkin),
        .rst     (rst),
        .inc     (tick_d),
        .clr     (clr),
        .sat     (sat),
        .counter (counter),
        .wrap    (wrap),
        .cnt_max (cnt_max)
    );

endmodule

// File: tb/tb_tick_prescaler.sv
// tb/tb_tick_prescaler.sv - scoreboard bench for tick_prescaler against an arithmetic reference model
module tb_tick_prescaler;

    localparam int N_BIT   = 16;
    localparam int CNT_BIT = 4;
    localparam int CMAX    = (1 << CNT_BIT) - 1;

    logic               clkin = 1'b0;
    logic               rst, enable, div_load, mode, sat, clr;
    logic [N_BIT-1:0]   div_value;
    logic               tick, wrap, cnt_max, busy;
    logic [N_BIT-1:0]   count;
    logic [CNT_BIT-1:0] counter;

    always #5 clkin = ~clkin;

    tick_prescaler #(
        .N_BIT   (N_BIT),
        .CNT_BIT (CNT_BIT)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .enable    (enable),
        .div_load  (div_load),
        .div_value (div_value),
        .mode      (mode),
        .sat       (sat),
        .clr       (clr),
        .tick      (tick),
        .count     (count),
        .counter   (counter),
        .wrap      (wrap),
        .cnt_max   (cnt_max),
        .busy      (busy)
    );

    typedef struct {
        bit tick;
        int count;
        int counter;
        bit wrap;
        bit cnt_max;
        bit busy;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: k counts prescaler steps since count was last zeroed,
    // so count = k mod (div+1) and a tick falls on every multiple.
    int m_div = 3, m_k = 0, m_ev = 0;
    bit m_mode = 0, m_started = 0, m_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_edge();
        exp_t e;
        bit   t = 1'b0;
        bit   w = 1'b0;
        if (rst) begin
            m_div = 3; m_mode = 0; m_started = 0; m_done = 0; m_k = 0; m_ev = 0;
        end else begin
            if (div_load) begin
                m_div = int'(div_value);
                m_k   = 0;
            end
            if (m_done) begin
                m_k = 0;
                if (!enable) begin
                    m_done = 0;
                    m_started = 0;
                end else if (div_load) begin
                    m_done = 0;
                end
            end else begin
                if (!m_started && enable) begin
                    m_started = 1;
                    m_mode    = mode;
                end
                if (m_started && enable && !div_load) begin
                    m_k++;
                    if (m_k % (m_div + 1) == 0) begin
                        t = 1'b1;
                        if (m_mode) begin
                            m_done = 1;
                            m_k    = 0;
                        end
                    end
                end
            end
            if (clr) begin
                m_ev = 0;
            end else if (t) begin
                if (m_ev == CMAX) begin
                    if (!sat) begin
                        m_ev = 0;
                        w = 1'b1;
                    end
                end else begin
                    m_ev++;
                end
            end
        end
        e.tick    = t;
        e.count   = m_k % (m_div + 1);
        e.counter = m_ev;
        e.wrap    = w;
        e.cnt_max = (m_ev == CMAX);
        e.busy    = m_started && !m_done;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clkin);
        model_edge();
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clkin);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_tick",    tick,    e.tick);
                chk("sb_count",   count,   e.count);
                chk("sb_counter", counter, e.counter);
                chk("sb_wrap",    wrap,    e.wrap);
                chk("sb_cnt_max", cnt_max, e.cnt_max);
                chk("sb_busy",    busy,    e.busy);
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int mask;
        int tcnt;
        rst = 1; enable = 0; div_load = 0; div_value = '0; mode = 0; sat = 0; clr = 0;
        step(); step();
        chk("rst_flags", {tick, wrap, cnt_max, busy}, 0);
        chk("rst_count", count, 0);
        chk("rst_counter", counter, 0);

        // Default divide: ticks on edges 4, 8, 12 after enable.
        rst = 0; enable = 1; mask = 0;
        for (int i = 1; i <= 12; i++) begin step(); if (tick) mask |= (1 << i); end
        chk("div3_tick_edges", mask, 32'h1110);
        chk("div3_counter", counter, 3);

        // Pause at count 2, then resume.
        step(); step();
        chk("pause_pre_count", count, 2);
        enable = 0; mask = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (tick) mask |= (1 << i);
            if (count != 2) mask |= 1;
        end
        chk("pause_hold", mask, 0);
        chk("pause_busy", busy, 1);
        enable = 1; mask = 0;
        for (int i = 1; i <= 3; i++) begin step(); if (tick) mask |= (1 << i); end
        chk("resume_tick_edge", mask, 32'h4);

        // Divide of zero loaded while running: tick every cycle.
        div_load = 1; div_value = '0;
        step();
        div_load = 0;
        chk("load_zero_tick", tick, 0);
        chk("load_zero_count", count, 0);
        tcnt = 0;
        for (int i = 0; i < 5; i++) begin step(); if (tick) tcnt++; end
        chk("div0_ticks", tcnt, 5);
        chk("div0_counter", counter, 9);

        // One-shot.
        rst = 1; step(); rst = 0;
        mode = 1; enable = 1; mask = 0;
        for (int i = 1; i <= 10; i++) begin step(); if (tick) mask |= (1 << i); end
        chk("oneshot_edges", mask, 32'h10);
        chk("oneshot_busy", busy, 0);
        enable = 0; step();
        enable = 1; mask = 0;
        for (int i = 1; i <= 10; i++) begin step(); if (tick) mask |= (1 << i); end
        chk("oneshot_rearm_edges", mask, 32'h10);
        chk("oneshot_counter", counter, 2);
        mode = 0;

        // Counter wrap and saturate.
        rst = 1; step(); rst = 0;
        enable = 1; div_load = 1; div_value = '0;
        step();
        div_load = 0;
        for (int i = 0; i < 15; i++) step();
        chk("wrap_pre_counter", counter, 15);
        chk("wrap_pre_max", cnt_max, 1);
        step();
        chk("wrap_counter", counter, 0);
        chk("wrap_pulse", wrap, 1);
        step();
        chk("wrap_post_counter", counter, 1);
        chk("wrap_post_pulse", wrap, 0);
        sat = 1;
        for (int i = 0; i < 19; i++) step();
        chk("sat_counter", counter, 15);
        chk("sat_max", cnt_max, 1);
        chk("sat_wrap", wrap, 0);

        // Clear coinciding with a tick at all-ones.
        sat = 0; clr = 1;
        step();
        clr = 0;
        chk("clr_tick", tick, 1);
        chk("clr_counter", counter, 0);
        chk("clr_wrap", wrap, 0);

        // Reset at count 3 discards the pending tick.
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 3; i++) step();
        chk("rstmid_pre_count", count, 3);
        rst = 1; step();
        chk("rstmid_flags", {tick, wrap, cnt_max, busy}, 0);
        chk("rstmid_count", count, 0);
        chk("rstmid_counter", counter, 0);
        rst = 0; mask = 0;
        for (int i = 1; i <= 4; i++) begin step(); if (tick) mask |= (1 << i); end
        chk("rstmid_first_tick", mask, 32'h10);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            enable    = ($urandom_range(0, 3) != 0);
            div_load  = ($urandom_range(0, 15) == 0);
            div_value = N_BIT'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            if ($urandom_range(0, 31) == 0) sat = ~sat;
            clr       = ($urandom_range(0, 31) == 0);
            step();
        end

        rst = 0; enable = 0; div_load = 0; clr = 0;
        @(negedge clkin);
        chk("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
